// File: rtl/bar_flag_filter_if.sv
// bar_flag_filter_if: bar word input stream plus tag/payload output stream.
interface bar_flag_filter_if;
    logic        in_valid;
    logic        in_ready;
    logic [20:0] in_bar;
    logic        pass_all;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_tag;
    logic [14:0] out_payload;
    modport master (
        output in_valid, in_bar, pass_all, out_ready,
        input  in_ready, out_valid, out_tag, out_payload
    );
    modport slave (
        input  in_valid, in_bar, pass_all, out_ready,
        output in_ready, out_valid, out_tag, out_payload
    );
endinterface

// File: rtl/bar_flag_filter.sv
// bar_flag_filter: keeps flagged (or all, in pass-through) bar words in a FWFT FIFO
// and counts dropped words with a saturating counter.
module bar_flag_filter #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    bar_flag_filter_if.slave         bus,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic [$clog2(DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    logic              rel_q;
    logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]       lvl_q, lvl_d;
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic [19:0]       mem_q [DEPTH];
    logic              acc, keep, pop;
    always_comb begin
        bus.in_ready = rel_q && (lvl_q != FULL);
        bus.out_valid = lvl_q != '0;
        acc = bus.in_valid && rel_q && (lvl_q != FULL);
        keep = acc && (bus.in_bar[15] || bus.pass_all);
        pop = (lvl_q != '0) && bus.out_ready;
        wr_d = keep ? wr_q + 1'b1 : wr_q;
        rd_d = pop ? rd_q + 1'b1 : rd_q;
        lvl_d = (keep && !pop) ? lvl_q + 1'b1 : (pop && !keep) ? lvl_q - 1'b1 : lvl_q;
        drop_d = (acc && !keep && !(&drop_q)) ? drop_q + 1'b1 : drop_q;
        {bus.out_tag, bus.out_payload} = (lvl_q != '0) ? mem_q[rd_q] : 20'd0;
    end
    // rel_q delays in_ready until the first clock after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rel_q  <= 1'b0;
            wr_q   <= '0;
            rd_q   <= '0;
            lvl_q  <= '0;
            drop_q <= '0;
        end else begin
            rel_q  <= 1'b1;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            lvl_q  <= lvl_d;
            drop_q <= drop_d;
        end
    end
    always_ff @(posedge clk) begin
        if (keep) mem_q[wr_q] <= {bus.in_bar[20:16], bus.in_bar[14:0]};
    end
    assign drop_cnt   = drop_q;
    assign fifo_level = lvl_q;
endmodule

// File: tb/tb_bar_flag_filter.sv
// tb_bar_flag_filter: directed and random checks against a queue-based reference model.
module tb_bar_flag_filter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst2_n = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [15:0] drop_a;
    logic [2:0]  lvl_a;
    logic [1:0]  drop_b;
    logic [2:0]  lvl_b;
    bar_flag_filter_if ia ();
    bar_flag_filter_if ib ();
    bar_flag_filter #(.DEPTH(4), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ia.slave), .drop_cnt(drop_a), .fifo_level(lvl_a)
    );
    bar_flag_filter #(.DEPTH(4), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst2_n), .bus(ib.slave), .drop_cnt(drop_b), .fifo_level(lvl_b)
    );
    always #5 clk = ~clk;
    logic [19:0] mq[$];
    int mdrop = 0;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    // Check instance A against the model, then advance model and DUT one clock.
    task automatic cycle();
        logic [19:0] head;
        bit acc, keep, pop;
        head = (mq.size() > 0) ? mq[0] : 20'd0;
        chk("in_ready", {31'd0, ia.in_ready}, {31'd0, mq.size() != 4});
        chk("out_valid", {31'd0, ia.out_valid}, {31'd0, mq.size() != 0});
        chk("out_tag", {27'd0, ia.out_tag}, {27'd0, head[19:15]});
        chk("out_payload", {17'd0, ia.out_payload}, {17'd0, head[14:0]});
        chk("fifo_level", {29'd0, lvl_a}, mq.size());
        chk("drop_cnt", {16'd0, drop_a}, mdrop);
        acc = ia.in_valid && mq.size() < 4;
        keep = acc && (ia.in_bar[15] || ia.pass_all);
        pop = mq.size() > 0 && ia.out_ready;
        if (pop) void'(mq.pop_front());
        if (keep) mq.push_back({ia.in_bar[20:16], ia.in_bar[14:0]});
        if (acc && !keep && mdrop < 65535) mdrop++;
        @(posedge clk);
        @(negedge clk);
    endtask
    task automatic drive(input bit v, input logic [20:0] bar, input bit pa, input bit rdy);
        ia.in_valid = v;
        ia.in_bar = bar;
        ia.pass_all = pa;
        ia.out_ready = rdy;
    endtask
    initial begin
        int dexp[5] = '{1, 2, 3, 3, 3};
        drive(0, '0, 0, 0);
        ib.in_valid = 0; ib.in_bar = '0; ib.pass_all = 0; ib.out_ready = 0;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, ia.in_ready}, 0);
        chk("rst_out_valid", {31'd0, ia.out_valid}, 0);
        chk("rst_out_tag", {27'd0, ia.out_tag}, 0);
        chk("rst_out_payload", {17'd0, ia.out_payload}, 0);
        chk("rst_drop", {16'd0, drop_a}, 0);
        chk("rst_level", {29'd0, lvl_a}, 0);
        rst_n = 1; rst2_n = 1;
        @(posedge clk);
        @(negedge clk);
        repeat (5) cycle();
        drive(1, 21'h1_8123, 0, 1);
        cycle();
        drive(0, '0, 0, 1);
        chk("first_valid", {31'd0, ia.out_valid}, 1);
        chk("first_tag", {27'd0, ia.out_tag}, 1);
        chk("first_payload", {17'd0, ia.out_payload}, 32'h0123);
        repeat (2) cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1, {5'(i + 2), 1'b0, 15'(16'h0100 + i)}, 0, 1);
            cycle();
        end
        drive(0, '0, 0, 1);
        cycle();
        chk("drop3", {16'd0, drop_a}, 3);
        for (int i = 0; i < 3; i++) begin
            drive(1, {5'(i + 7), 1'b0, 15'(16'h0200 + i)}, 1, 1);
            cycle();
        end
        drive(0, '0, 0, 1);
        repeat (4) cycle();
        chk("drop_still3", {16'd0, drop_a}, 3);
        for (int i = 1; i <= 5; i++) begin
            drive(1, {5'(i), 1'b1, 15'(i)}, 0, 0);
            cycle();
        end
        chk("full_level", {29'd0, lvl_a}, 4);
        chk("full_ready", {31'd0, ia.in_ready}, 0);
        drive(0, '0, 0, 1);
        repeat (6) cycle();
        drive(1, 21'h0_8AAA, 0, 0);
        repeat (2) cycle();
        for (int i = 0; i < 6; i++) begin
            drive(1, {5'(i + 16), 1'b1, 15'(16'h0300 + i)}, 0, 1);
            cycle();
            chk("steady_level", {29'd0, lvl_a}, 2);
        end
        drive(0, '0, 0, 1);
        repeat (3) cycle();
        repeat (300) begin
            drive(($urandom_range(0, 9) < 7), 21'($urandom), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 9) < 6));
            cycle();
        end
        drive(0, '0, 0, 1);
        repeat (5) cycle();
        ib.in_valid = 1; ib.in_bar = 21'h0_0005;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("sat_drop", {30'd0, drop_b}, dexp[i]);
        end
        ib.in_bar = 21'h0_8001;
        repeat (2) @(posedge clk);
        @(negedge clk);
        ib.in_valid = 0;
        chk("b_level2", {29'd0, lvl_b}, 2);
        chk("b_valid", {31'd0, ib.out_valid}, 1);
        #2 rst2_n = 0;
        #1;
        chk("b_rst_valid", {31'd0, ib.out_valid}, 0);
        chk("b_rst_drop", {30'd0, drop_b}, 0);
        chk("b_rst_level", {29'd0, lvl_b}, 0);
        chk("b_rst_ready", {31'd0, ib.in_ready}, 0);
        @(negedge clk);
        rst2_n = 1;
        ib.out_ready = 1;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk("b_post_valid", {31'd0, ib.out_valid}, 0);
            chk("b_post_ready", {31'd0, ib.in_ready}, 1);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bar_flag_filter.md
Name: bar_flag_filter

Overview:
- Downstream consumer of the bar_struct_t stream: a 21-bit packed word whose bit 15 is the flag field.
- Accepts bar words on a valid/ready interface.
- Keeps only flagged words, unless pass-through mode is on, and buffers them in a small FIFO.
- Presents each kept word to the next stage as separate tag and payload fields.
- Keeps a saturating count of the words it drops.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- CNT_W, 16, width of the drop counter.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word this cycle.
- in_bar  input  21  bar_struct_t word. Field layout: [20:16] tag, [15] flag, [14:0] payload.
- pass_all  input  1  1 = keep every word regardless of flag; sampled on acceptance.
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream accepts the head entry.
- out_tag  output  5  tag of the head entry.
- out_payload  output  15  payload of the head entry.
- drop_cnt  output  CNT_W  saturating count of dropped words.
- fifo_level  output  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset: asynchronous on rst_n low, released synchronously to clk.
  - Clears read pointer, write pointer, level and drop_cnt.
  - Outputs in reset: in_ready=0, out_valid=0, out_tag=0, out_payload=0, drop_cnt=0, fifo_level=0.
  - Storage RAM is not reset.
- in_ready = rst_n_released && (fifo_level != DEPTH).
  - Registered/derived from state only; never a function of in_valid, in_bar or pass_all.
- Accept = in_valid && in_ready.
  - On accept, the word is kept if in_bar[15]==1 or pass_all==1; otherwise it is dropped.
- Keep: write {tag, payload} at the write pointer; the write pointer advances, wrapping modulo DEPTH.
- Drop: nothing is written; drop_cnt increments by 1, saturating at all-ones and holding there until reset.
- Pop = out_valid && out_ready. The read pointer advances, wrapping modulo DEPTH.
- out_valid = (fifo_level != 0).
  - The head is shown first-word-fall-through from storage.
  - out_tag and out_payload are forced to 0 whenever out_valid=0.
- Latency: a kept word accepted in cycle N is visible with out_valid=1 in cycle N+1 at the earliest. There is no combinational in-to-out bypass.
- Level update per cycle:
  - +1 for keep without pop.
  - −1 for pop without keep.
  - unchanged when both or neither occur.
  - A dropped word never changes the level.
- Full (level==DEPTH): in_ready=0. A pop in that cycle frees an entry, but in_ready rises only in the next cycle.
- Empty (level==0): a pop cannot occur; out_ready is ignored.
- Simultaneous keep and pop at any level from 1 to DEPTH-1: both happen, level is unchanged, order is preserved.
- Ordering: kept words leave strictly in acceptance order.
- Output stability: while out_valid=1 and out_ready=0, out_tag and out_payload hold stable.
- Reset mid-operation: all buffered words are discarded and drop_cnt clears. After release, the block behaves exactly as after power-up.
- Occupancy control is the pointer pair plus level counter. There is no separate state machine.

Test Plan:
- Reset, then idle 5 cycles -> in_ready=1 from the first post-reset cycle; out_valid=0, out_tag=0, out_payload=0, drop_cnt=0, fifo_level=0.
- Accept in_bar=21'h1_8123 (tag=1, flag=1, payload=15'h0123) with out_ready=1 -> the next cycle shows out_valid=1, out_tag=1, out_payload=0x0123; fifo_level goes 1 then 0 after the pop.
- Accept 3 words with bit15=0 and pass_all=0 -> no out_valid, drop_cnt=3, fifo_level=0. Repeat with pass_all=1 -> all 3 emerge in order and drop_cnt stays 3.
- With out_ready=0, push DEPTH=4 flagged words with payloads 1..4 -> fifo_level=4 and in_ready=0; a 5th word is held off. Raise out_ready -> payloads 1,2,3,4 emerge in order; in_ready returns the cycle after the first pop.
- Hold level at 2, then keep and pop in the same cycle for 6 cycles -> level stays 2; pointers wrap; output order matches input order.
- CNT_W=2 override, drop 5 words -> drop_cnt reads 1,2,3,3,3. Then pulse rst_n low mid-burst with 2 entries buffered -> out_valid=0 and drop_cnt=0 immediately; the buffered entries never appear.
